weight_dispatch: RTL

- Sits directly downstream of the BRAM weight read controller. Consumes its `weight_out`/`data_valid` stream and drives its `read_en`, `read_length` and `address_reset` pins.
- Fetches exactly `row_count` weight lines per command from address 0. Uses paired A+B fetches when at least 2 rows remain.
- Buffers lines in a small FIFO and presents them to the MAC array over a valid/ready handshake, flagging the last row.

---
 rtl/weight_dispatch.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/weight_dispatch.sv
// weight_dispatch: fetches row_count weight lines from the BRAM read controller
// (paired A+B fetches while at least two rows remain), buffers them in a small
// FIFO and hands them to the MAC array over valid/ready, flagging the last row.
// Optional: define WEIGHT_DISPATCH_PERF_EN to add back-pressure/starvation counters.
module weight_dispatch #(
    parameter int unsigned MAC_NUM       = 256,
    parameter int unsigned ROW_CNT_WIDTH = 12,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ROW_CNT_WIDTH-1:0] row_count,
    output logic                     busy,
    output logic                     done,
    input  logic [5*MAC_NUM-1:0]     weight_in,
    input  logic                     weight_in_valid,
    output logic                     read_en,
    output logic                     read_length,
    output logic                     address_reset,
    output logic [5*MAC_NUM-1:0]     mac_weight,
    output logic                     mac_weight_valid,
    output logic                     mac_weight_last,
    input  logic                     mac_weight_ready
`ifdef WEIGHT_DISPATCH_PERF_EN
    ,
    output logic [31:0]              stall_bp_cnt,
    output logic [31:0]              stall_starve_cnt
`endif
);

    localparam int unsigned LineW = 5 * MAC_NUM;
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {StIdle, StRstAddr, StFetch, StDrain, StDone} state_e;

    state_e                   state_q, state_d;
    logic [ROW_CNT_WIDTH-1:0] rows_q, rows_d;
    logic [ROW_CNT_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [ROW_CNT_WIDTH-1:0] sent_cnt_q, sent_cnt_d;
    logic [ROW_CNT_WIDTH-1:0] fetch_rem;
    logic                     expect_b_q, expect_b_d;
    logic                     busy_q, done_q, addr_rst_q;

    logic [LineW-1:0]         mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]          fifo_cnt_q, fifo_cnt_d;
    logic                     in_fetch, fifo_full, pop;

    assign fetch_rem = rows_q - fetch_cnt_q;
    assign in_fetch  = (state_q == StFetch);
    // Registered occupancy only: a same-cycle pop never grants room for a push.
    assign fifo_full = (fifo_cnt_q == CntW'(FIFO_DEPTH));

    assign read_en     = in_fetch && weight_in_valid && (fetch_rem != '0) && !fifo_full;
    assign read_length = in_fetch && !expect_b_q && (fetch_rem >= ROW_CNT_WIDTH'(2));

    assign mac_weight_valid = (fifo_cnt_q != '0);
    assign mac_weight_last  = mac_weight_valid && (sent_cnt_q == rows_q - ROW_CNT_WIDTH'(1));
    // Head is masked while empty so the bus idles at zero.
    assign mac_weight       = mac_weight_valid ? mem_q[rd_ptr_q] : '0;
    assign pop              = mac_weight_valid && mac_weight_ready
                              && ((state_q == StFetch) || (state_q == StDrain));

    assign busy          = busy_q;
    assign done          = done_q;
    assign address_reset = addr_rst_q;

    // Next-state decode for the command sequencer.
    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rows_d  = row_count;
                    state_d = (row_count != '0) ? StRstAddr : StDone;
                end
            end
            StRstAddr: state_d = StFetch;
            StFetch:   if (fetch_rem == '0) state_d = StDrain;
            StDrain:   if (sent_cnt_q == rows_q) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Sequencer state with outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rows_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_d == StDone);
            addr_rst_q <= (state_d == StRstAddr);
        end
    end

    // Fetch/send progress, A/B pairing and FIFO occupancy.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        sent_cnt_d  = sent_cnt_q;
        expect_b_d  = expect_b_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (state_q == StRstAddr) begin
            fetch_cnt_d = '0;
            sent_cnt_d  = '0;
            expect_b_d  = 1'b0;
        end else begin
            if (read_en) begin
                fetch_cnt_d = fetch_cnt_q + ROW_CNT_WIDTH'(1);
                if (read_length) begin
                    expect_b_d = 1'b1;
                end else if (expect_b_q) begin
                    expect_b_d = 1'b0;
                end
            end
            if (pop) begin
                sent_cnt_d = sent_cnt_q + ROW_CNT_WIDTH'(1);
            end
        end
        if (read_en && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CntW'(1);
        end else if (!read_en && pop) begin
            fifo_cnt_d = fifo_cnt_q - CntW'(1);
        end
    end

    // Counter and FIFO pointer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            sent_cnt_q  <= '0;
            expect_b_q  <= 1'b0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            sent_cnt_q  <= sent_cnt_d;
            expect_b_q  <= expect_b_d;
            fifo_cnt_q  <= fifo_cnt_d;
            if (read_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Line storage; no reset needed since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (read_en) mem_q[wr_ptr_q] <= weight_in;
    end

`ifdef WEIGHT_DISPATCH_PERF_EN
    logic [31:0] bp_cnt_q, starve_cnt_q;

    // Saturating stall counters, cleared at the start of each command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_cnt_q     <= '0;
            starve_cnt_q <= '0;
        end else if (state_q == StRstAddr) begin
            bp_cnt_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            if (mac_weight_valid && !mac_weight_ready && (bp_cnt_q != '1)) begin
                bp_cnt_q <= bp_cnt_q + 32'd1;
            end
            if (in_fetch && !mac_weight_valid && (starve_cnt_q != '1)) begin
                starve_cnt_q <= starve_cnt_q + 32'd1;
            end
        end
    end

    assign stall_bp_cnt     = bp_cnt_q;
    assign stall_starve_cnt = starve_cnt_q;
`endif

endmodule
